// File: rtl/tea_engine.sv
// tea_engine: iterative TEA block cipher, encipher or decipher per request, one half-round per step.
// Optional build macro TEA_MULTICYCLE_EN splits each half-round into an F stage and an add/sub stage.
module tea_engine #(
    parameter int                   WORD_SIZE    = 32,
    parameter logic [WORD_SIZE-1:0] DELTA        = 32'h9e3779b9,
    parameter int                   ROUND_NUMBER = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 iValid,
    output logic                 oReady,
    input  logic                 iMode,
    input  logic [WORD_SIZE-1:0] iV0,
    input  logic [WORD_SIZE-1:0] iV1,
    input  logic [WORD_SIZE-1:0] iK0,
    input  logic [WORD_SIZE-1:0] iK1,
    input  logic [WORD_SIZE-1:0] iK2,
    input  logic [WORD_SIZE-1:0] iK3,
    output logic                 oValid,
    input  logic                 iReady,
    output logic [WORD_SIZE-1:0] oC0,
    output logic [WORD_SIZE-1:0] oC1,
    output logic                 oBusy
);
    localparam int                   CW       = $clog2(ROUND_NUMBER + 1);
    localparam logic [63:0]          SUM_PROD = 64'(DELTA) * 64'(ROUND_NUMBER);
    localparam logic [WORD_SIZE-1:0] SUM_DEC  = SUM_PROD[WORD_SIZE-1:0];
    localparam logic [CW-1:0]        CNT_LAST = CW'(ROUND_NUMBER - 1);

    typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;

    state_t               state;
    logic                 mode;
    logic                 half;
    logic [CW-1:0]        cnt;
    logic [WORD_SIZE-1:0] sum;
    logic [WORD_SIZE-1:0] k0, k1, k2, k3;
    logic                 sel;
    logic                 apply_en;
    logic [WORD_SIZE-1:0] f_val;
    logic [WORD_SIZE-1:0] step;

    function automatic logic [WORD_SIZE-1:0] tea_f(
        input logic [WORD_SIZE-1:0] x,
        input logic [WORD_SIZE-1:0] ka,
        input logic [WORD_SIZE-1:0] kb,
        input logic [WORD_SIZE-1:0] s
    );
        tea_f = ((x << 4) + ka) ^ (x + s) ^ ((x >> 5) + kb);
    endfunction

    // sel=0 updates C0 from C1 with K0/K1; sel=1 updates C1 from C0 with K2/K3.
    // Decipher walks the two halves in the opposite order, hence the XOR with mode.
    always_comb begin
        sel = mode ^ half;
        if (sel) f_val = tea_f(oC0, k2, k3, sum);
        else     f_val = tea_f(oC1, k0, k1, sum);
    end

`ifdef TEA_MULTICYCLE_EN
    logic                 phase;
    logic [WORD_SIZE-1:0] aux;
    assign step     = aux;
    assign apply_en = phase;
`else
    assign step     = f_val;
    assign apply_en = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            oReady <= 1'b1;
            oValid <= 1'b0;
            oBusy  <= 1'b0;
            oC0    <= '0;
            oC1    <= '0;
            mode   <= 1'b0;
            half   <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            k0     <= '0;
            k1     <= '0;
            k2     <= '0;
            k3     <= '0;
`ifdef TEA_MULTICYCLE_EN
            phase  <= 1'b0;
            aux    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (iValid) begin
                        oC0    <= iV0;
                        oC1    <= iV1;
                        k0     <= iK0;
                        k1     <= iK1;
                        k2     <= iK2;
                        k3     <= iK3;
                        mode   <= iMode;
                        sum    <= iMode ? SUM_DEC : DELTA;
                        cnt    <= '0;
                        half   <= 1'b0;
`ifdef TEA_MULTICYCLE_EN
                        phase  <= 1'b0;
`endif
                        state  <= RUN;
                        oReady <= 1'b0;
                        oBusy  <= 1'b1;
                    end
                end
                RUN: begin
`ifdef TEA_MULTICYCLE_EN
                    phase <= ~phase;
                    if (!phase) aux <= f_val;
`endif
                    if (apply_en) begin
                        if (sel) oC1 <= mode ? oC1 - step : oC1 + step;
                        else     oC0 <= mode ? oC0 - step : oC0 + step;
                        half <= ~half;
                        if (half) begin
                            sum <= mode ? sum - DELTA : sum + DELTA;
                            cnt <= cnt + CW'(1);
                            if (cnt == CNT_LAST) begin
                                state  <= OUT;
                                oBusy  <= 1'b0;
                                oValid <= 1'b1;
                            end
                        end
                    end
                end
                OUT: begin
                    if (iReady) begin
                        state  <= IDLE;
                        oValid <= 1'b0;
                        oReady <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tea_engine.sv
// tb_tea_engine: table-driven vectors with a result scoreboard for tea_engine (32-bit, R=32)
// plus two 16-bit instances (R=1, R=5) for the parameter sweep.
module tb_tea_engine;
    localparam int R = 32;
`ifdef TEA_MULTICYCLE_EN
    localparam int SPH = 2;
`else
    localparam int SPH = 1;
`endif

    typedef struct {
        logic [31:0] c0;
        logic [31:0] c1;
    } res_t;

    typedef struct {
        bit          mode;
        logic [31:0] v0, v1, k0, k1, k2, k3, e0, e1;
        string       name;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, iValid, iMode, iReady, oReady, oValid, oBusy;
    logic [31:0] iV0, iV1, iK0, iK1, iK2, iK3, oC0, oC1;
    logic        s_valid, a_ready, a_valid, a_busy, b_ready, b_valid, b_busy;
    logic [15:0] a_c0, a_c1, b_c0, b_c1;

    int   checks = 0;
    int   errors = 0;
    res_t sb[$];
    res_t qa[$];
    res_t qb[$];
    vec_t tbl[4];

    always #5 clk = ~clk;

    tea_engine u_dut (
        .clk(clk), .rst(rst), .iValid(iValid), .oReady(oReady), .iMode(iMode),
        .iV0(iV0), .iV1(iV1), .iK0(iK0), .iK1(iK1), .iK2(iK2), .iK3(iK3),
        .oValid(oValid), .iReady(iReady), .oC0(oC0), .oC1(oC1), .oBusy(oBusy)
    );

    tea_engine #(.WORD_SIZE(16), .DELTA(16'h79b9), .ROUND_NUMBER(1)) u_r1 (
        .clk(clk), .rst(rst), .iValid(s_valid), .oReady(a_ready), .iMode(iMode),
        .iV0(iV0[15:0]), .iV1(iV1[15:0]), .iK0(iK0[15:0]), .iK1(iK1[15:0]),
        .iK2(iK2[15:0]), .iK3(iK3[15:0]),
        .oValid(a_valid), .iReady(iReady), .oC0(a_c0), .oC1(a_c1), .oBusy(a_busy)
    );

    tea_engine #(.WORD_SIZE(16), .DELTA(16'h79b9), .ROUND_NUMBER(5)) u_r5 (
        .clk(clk), .rst(rst), .iValid(s_valid), .oReady(b_ready), .iMode(iMode),
        .iV0(iV0[15:0]), .iV1(iV1[15:0]), .iK0(iK0[15:0]), .iK1(iK1[15:0]),
        .iK2(iK2[15:0]), .iK3(iK3[15:0]),
        .oValid(b_valid), .iReady(iReady), .oC0(b_c0), .oC1(b_c1), .oBusy(b_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_f(input logic [31:0] x, ka, kb, s, mask);
        ref_f = ((((x << 4) & mask) + ka) ^ (x + s) ^ ((x >> 5) + kb)) & mask;
    endfunction

    // Textbook TEA loop: sum advances before each encipher round, after each decipher round.
    task automatic tea_ref(input bit m, input logic [31:0] v0_in, v1_in, k0, k1, k2, k3,
                           input int w, input int r, input logic [31:0] dl,
                           output logic [31:0] c0, output logic [31:0] c1);
        logic [31:0] mask, v0, v1, sum;
        mask = (w >= 32) ? 32'hffffffff : ((32'h1 << w) - 32'h1);
        v0 = v0_in & mask;  v1 = v1_in & mask;
        k0 &= mask; k1 &= mask; k2 &= mask; k3 &= mask;
        if (!m) begin
            sum = 32'h0;
            for (int i = 0; i < r; i++) begin
                sum = (sum + dl) & mask;
                v0  = (v0 + ref_f(v1, k0, k1, sum, mask)) & mask;
                v1  = (v1 + ref_f(v0, k2, k3, sum, mask)) & mask;
            end
        end else begin
            sum = (dl * r) & mask;
            for (int i = 0; i < r; i++) begin
                v1  = (v1 - ref_f(v0, k2, k3, sum, mask)) & mask;
                v0  = (v0 - ref_f(v1, k0, k1, sum, mask)) & mask;
                sum = (sum - dl) & mask;
            end
        end
        c0 = v0;
        c1 = v1;
    endtask

    task automatic scramble();
        iV0 = $urandom; iV1 = $urandom;
        iK0 = $urandom; iK1 = $urandom; iK2 = $urandom; iK3 = $urandom;
    endtask

    task automatic send(input bit m, input logic [31:0] v0, v1, k0, k1, k2, k3, e0, e1);
        int   n = 0;
        res_t r;
        while (!oReady && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("ready_before_send", {31'h0, oReady}, 32'h1);
        iMode = m; iV0 = v0; iV1 = v1; iK0 = k0; iK1 = k1; iK2 = k2; iK3 = k3;
        iValid = 1'b1;
        r.c0 = e0; r.c1 = e1;
        sb.push_back(r);
        @(posedge clk); #1;
        iValid = 1'b0;
        iMode  = ~m;
        scramble();
        check("busy_after_accept", {31'h0, oBusy}, 32'h1);
        check("ready_after_accept", {31'h0, oReady}, 32'h0);
    endtask

    task automatic collect(input string name, input int lat, input bit hold);
        int   n = 0;
        res_t r;
        while (!oValid && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        check({name, "_latency"}, n, lat);
        check({name, "_sb_depth"}, sb.size(), 1);
        if (sb.size() > 0) begin
            r = sb.pop_front();
            check({name, "_c0"}, oC0, r.c0);
            check({name, "_c1"}, oC1, r.c1);
            if (hold) begin
                for (int i = 0; i < 20; i++) begin
                    iValid = i[0];
                    iMode  = ~iMode;
                    scramble();
                    @(posedge clk); #1;
                    check("bp_valid", {31'h0, oValid}, 32'h1);
                    check("bp_ready", {31'h0, oReady}, 32'h0);
                    check("bp_c0", oC0, r.c0);
                    check("bp_c1", oC1, r.c1);
                end
                iValid = 1'b0;
            end
        end
        iReady = 1'b1;
        @(posedge clk); #1;
        iReady = 1'b0;
        check({name, "_valid_drop"}, {31'h0, oValid}, 32'h0);
        check({name, "_ready_back"}, {31'h0, oReady}, 32'h1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] e0, e1, ea0, ea1, eb0, eb1;
        logic [31:0] sv0, sv1;
        res_t        r;
        int          n, la, lb;

        rst = 1'b0; iValid = 1'b0; iMode = 1'b0; iReady = 1'b0; s_valid = 1'b0;
        iV0 = 32'h0; iV1 = 32'h0; iK0 = 32'h0; iK1 = 32'h0; iK2 = 32'h0; iK3 = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'h0, oReady}, 32'h1);
        check("rst_valid", {31'h0, oValid}, 32'h0);
        check("rst_busy", {31'h0, oBusy}, 32'h0);
        check("rst_c0", oC0, 32'h0);
        check("rst_c1", oC1, 32'h0);
        check("rst_r1_ready", {31'h0, a_ready}, 32'h1);
        check("rst_r5_valid", {31'h0, b_valid}, 32'h0);
        rst = 1'b1;

        tbl[0] = '{mode: 1'b0, v0: 32'h0, v1: 32'h0, k0: 32'h0, k1: 32'h0, k2: 32'h0, k3: 32'h0,
                   e0: 32'h41ea3a0a, e1: 32'h94baa940, name: "enc_zero"};
        tbl[1] = '{mode: 1'b1, v0: 32'h41ea3a0a, v1: 32'h94baa940, k0: 32'h0, k1: 32'h0,
                   k2: 32'h0, k3: 32'h0, e0: 32'h0, e1: 32'h0, name: "dec_zero"};
        tea_ref(1'b0, 32'hdeadbeef, 32'hcafebabe, 32'h01234567, 32'h89abcdef,
                32'hfedcba98, 32'h76543210, 32, R, 32'h9e3779b9, e0, e1);
        tbl[2] = '{mode: 1'b0, v0: 32'hdeadbeef, v1: 32'hcafebabe, k0: 32'h01234567,
                   k1: 32'h89abcdef, k2: 32'hfedcba98, k3: 32'h76543210,
                   e0: e0, e1: e1, name: "enc_rt"};
        tbl[3] = '{mode: 1'b1, v0: e0, v1: e1, k0: 32'h01234567, k1: 32'h89abcdef,
                   k2: 32'hfedcba98, k3: 32'h76543210,
                   e0: 32'hdeadbeef, e1: 32'hcafebabe, name: "dec_rt"};

        for (int i = 0; i < 4; i++) begin
            send(tbl[i].mode, tbl[i].v0, tbl[i].v1, tbl[i].k0, tbl[i].k1, tbl[i].k2, tbl[i].k3,
                 tbl[i].e0, tbl[i].e1);
            collect(tbl[i].name, 2 * R * SPH, i == 2);
        end

        // Reset lands at edge 30 of a run; the in-flight block must vanish.
        send(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h41ea3a0a, 32'h94baa940);
        repeat (29) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        sb.delete();
        check("midrst_busy", {31'h0, oBusy}, 32'h0);
        check("midrst_valid", {31'h0, oValid}, 32'h0);
        check("midrst_ready", {31'h0, oReady}, 32'h1);
        check("midrst_c0", oC0, 32'h0);
        check("midrst_c1", oC1, 32'h0);
        rst = 1'b1;
        send(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h41ea3a0a, 32'h94baa940);
        collect("after_rst", 2 * R * SPH, 1'b0);

        for (int m = 0; m < 2; m++) begin
            sv0 = (m == 0) ? 32'h1234 : 32'hbeef;
            sv1 = (m == 0) ? 32'habcd : 32'h0042;
            tea_ref(m[0], sv0, sv1, 32'h0f1e, 32'h2d3c, 32'h4b5a, 32'h6978, 16, 1, 32'h79b9, ea0, ea1);
            tea_ref(m[0], sv0, sv1, 32'h0f1e, 32'h2d3c, 32'h4b5a, 32'h6978, 16, 5, 32'h79b9, eb0, eb1);
            r.c0 = ea0; r.c1 = ea1; qa.push_back(r);
            r.c0 = eb0; r.c1 = eb1; qb.push_back(r);
            iMode = m[0]; iV0 = sv0; iV1 = sv1;
            iK0 = 32'h0f1e; iK1 = 32'h2d3c; iK2 = 32'h4b5a; iK3 = 32'h6978;
            s_valid = 1'b1;
            @(posedge clk); #1;
            s_valid = 1'b0;
            iMode = ~iMode;
            scramble();
            la = -1; lb = -1; n = 0;
            while ((la < 0 || lb < 0) && n < 200) begin
                @(posedge clk); #1; n++;
                if (a_valid && la < 0) la = n;
                if (b_valid && lb < 0) lb = n;
            end
            check("r1_latency", la, 2 * SPH);
            check("r5_latency", lb, 10 * SPH);
            r = qa.pop_front();
            check("r1_c0", {16'h0, a_c0}, r.c0);
            check("r1_c1", {16'h0, a_c1}, r.c1);
            r = qb.pop_front();
            check("r5_c0", {16'h0, b_c0}, r.c0);
            check("r5_c1", {16'h0, b_c1}, r.c1);
            iReady = 1'b1;
            @(posedge clk); #1;
            iReady = 1'b0;
            check("r1_ready_back", {31'h0, a_ready}, 32'h1);
            check("r5_ready_back", {31'h0, b_ready}, 32'h1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tea_engine.md
# tea_engine

Parametrised TEA block-cipher core that both enciphers and deciphers one 2-word block per transaction, selected per request by a mode input. It generalises the single-direction decipher engine: configurable word size, round count and delta; a valid/ready handshake on input and output; a per-transaction mode bit; and operands captured at acceptance. It sits between the host-side block buffer and the result FIFO in the crypto datapath.

## Interface
- WORD_SIZE, 32, width of V0/V1/key words and of sum.
- DELTA, 32'h9e3779b9, key-schedule constant, truncated to WORD_SIZE.
- ROUND_NUMBER, 32, full rounds per block, ≥1.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset: synchronous, active-low.
- iValid  in  1  request valid.
- oReady  out  1  engine can accept a request; reset 1.
- iMode  in  1  0 = encipher, 1 = decipher; sampled at acceptance.
- iV0, iV1  in  WORD_SIZE  input block.
- iK0..iK3  in  WORD_SIZE each  key words.
- oValid  out  1  result valid; reset 0.
- iReady  in  1  downstream accepts result.
- oC0, oC1  out  WORD_SIZE  result block; reset 0.
- oBusy  out  1  high in RUN; reset 0.

## Operation
- States: IDLE, RUN, OUT. Reset → IDLE.
- IDLE: oReady=1. On iValid&&oReady: latch iV0/iV1 into oC0/oC1, latch K0..K3 and mode, clear round counter and half flag, → RUN. Otherwise hold.
- Initial sum: encipher = DELTA; decipher = DELTA*ROUND_NUMBER mod 2^WORD_SIZE (elaboration-time constant).
- F(x, ka, kb, s) = ((x<<4)+ka) ^ (x+s) ^ ((x>>5)+kb), all mod 2^WORD_SIZE, logical shifts.
- Encipher round: half0 C0 += F(C1,K0,K1,sum); half1 C1 += F(C0,K2,K3,sum) using updated C0; then sum += DELTA.
- Decipher round: half0 C1 -= F(C0,K2,K3,sum); half1 C0 -= F(C1,K0,K1,sum) using updated C1; then sum -= DELTA.
- Round counter increments after half1; when it reaches ROUND_NUMBER → OUT. Counter width $clog2(ROUND_NUMBER+1).
- OUT: oValid=1, oC0/oC1 stable. On iReady → IDLE (oValid low next cycle). oValid never drops without iReady.
- iValid while not IDLE is ignored; input ports may change freely after acceptance.
- Reset asserted in any state, mid-round included: next edge → IDLE, oReady=1, oValid=0, oBusy=0, oC0/oC1=0, counter/sum/keys cleared; in-flight block discarded.
- iMode/keys in the acceptance cycle are the only ones used; they are not re-sampled.

## Timing
- Acceptance edge E0. Without macro: one half-round per edge E1..E2R (R=ROUND_NUMBER); oValid high after edge E2R → latency 2R cycles (64 for defaults).
- Result accepted at edge Eo when oValid&&iReady; oReady high after Eo; next acceptance earliest Eo+1 (one bubble; throughput one block per 2R+2 cycles).
- oReady, oValid, oBusy are registered state decodes; no combinational path from iValid/iReady to any output.

## Configuration
- TEA_MULTICYCLE_EN defined: each half-round takes two edges — first registers F into an internal aux register, second applies add/sub to oC0/oC1 (and sum update on the second edge of half1). Latency 4R cycles (128 default); shortens critical path to one adder+XOR stage.
- Not defined: F and the add/sub resolve in one cycle; latency 2R. Functional results identical in both builds.

## Test plan
- Encipher, key 0,0,0,0, V=(0,0), R=32 → oC0=32'h41ea3a0a, oC1=32'h94baa940; oValid after exactly 64 cycles (128 with macro).
- Decipher, key 0, V=(32'h41ea3a0a,32'h94baa940) → oC0=0, oC1=0.
- Round trip, key (32'h01234567,32'h89abcdef,32'hfedcba98,32'h76543210), V=(32'hdeadbeef,32'hcafebabe): encipher then decipher result → original V; compare against C reference model for both steps.
- Backpressure: hold iReady=0 for 20 cycles in OUT → oValid stays 1, oC0/oC1 unchanged, oReady=0, iValid pulses ignored; iReady=1 → oReady=1 next cycle.
- Reset mid-op: rst=0 at cycle 30 of a run → next edge oBusy=0, oValid=0, oReady=1, oC0=oC1=0; new request after reset gives correct vector-1 result.
- Parameter sweep: WORD_SIZE=16, DELTA=16'h79b9, ROUND_NUMBER=1 and 5 → matches model; latency 2 and 10 cycles.
